conv_window_buffer: RTL and testbench
=====================================

Name: conv_window_buffer

Overview:
- Streaming front-end for the conv PE. Accepts one Q8.24 sample per handshake and keeps an N_REG-deep sliding window with zero padding at head and tail.
- Emits the flattened window bus `all_a` at the conv stride, using valid/ready toward the PE/weight sequencer.
- One instance feeds the `all_a` operand of one PE column for one frame per `start`.

Parameters:
- WIDTH, 32, sample width, signed Q(WIDTH-FBITS).FBITS.
- N_REG, 31, kernel taps (window depth).
- STRIDE, 2, input samples advanced per output window.
- PAD, 15, zero samples at head and tail of the frame; legal range 0..N_REG-1.
- FRAME_LEN, 16384, real input samples per frame.
- CNT_BITS, 15, width of counters and of `win_idx`.
- Localparam N_OUT = (FRAME_LEN+2*PAD-N_REG)/STRIDE+1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- in_valid  in  1  `in_data` valid.
- in_data  in  WIDTH  signed input sample.
- in_ready  out  1  block accepts `in_data` this cycle.
- win_valid  out  1  `all_a` / `win_idx` hold a complete window.
- win_ready  in  1  consumer accepts the window.
- all_a  out  N_REG*WIDTH  window; slice i = `all_a[i*WIDTH +: WIDTH]`; i=0 is the oldest sample.
- win_idx  out  CNT_BITS  output index of the presented window, 0..N_OUT-1.
- busy  out  1  high from the cycle after an accepted `start` until `done`.
- done  out  1  one-cycle pulse after the last window is accepted.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; shift register all zero; all counters zero; all outputs 0 (`in_ready`, `win_valid`, `busy`, `done`, `win_idx`, `all_a`).
- States: IDLE -> STREAM -> TAIL -> DRAIN -> IDLE.
- IDLE: `start`=1 clears the shift register, loads vcnt=PAD and rcnt=0, and sets busy.
  - Loading vcnt=PAD is equivalent to PAD leading zeros already shifted in.
  - `start` outside IDLE is ignored.
- Shift operation:
  - Slice i takes slice i+1; slice N_REG-1 takes the new value; vcnt increments.
  - After the shift, if vcnt>=N_REG and (vcnt-N_REG)%STRIDE==0, `win_valid` is registered high on the next edge with `win_idx`=ocnt.
  - `all_a` is the shift register itself.
- Advance condition: adv = (!win_valid || win_ready).
  - A window accepted (win_valid && win_ready) with no new window formed clears `win_valid` next cycle.
  - Acceptance increments ocnt.
- STREAM:
  - `in_ready` = adv && rcnt<FRAME_LEN && ocnt_formed<N_OUT.
  - On in_valid && in_ready: shift in `in_data`, rcnt++.
  - When rcnt reaches FRAME_LEN, go to TAIL.
  - No bubbles: accept-and-shift in the same cycle is permitted. Steady state is one window per STRIDE accepted samples.
- TAIL:
  - Shifts zero (ignores `in_valid`, `in_ready`=0) every cycle adv=1, until N_OUT windows have been formed.
  - If all N_OUT windows were already formed in STREAM (e.g. PAD=0), TAIL makes no shifts.
- DRAIN: wait for acceptance of the final window, pulse `done`, clear `busy`, return to IDLE.
- Backpressure: while win_valid && !win_ready, `all_a`/`win_idx`/`win_valid` remain stable and no shift occurs.
- Arithmetic: data is moved only, never modified; padding inserts literal zero (all bits 0).
- rst_n low mid-frame: immediate return to reset state on that edge; the partial window is discarded.

Optional Feature:
- Macro CWB_STALL_CNT_EN.
  - Defined: adds output `stall_cnt` [31:0]. It increments every cycle win_valid && !win_ready while busy, saturates at 2^32-1, clears on reset and on accepted `start`, and holds after `done`.
  - Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Config N_REG=5, PAD=2, STRIDE=2, FRAME_LEN=8, win_ready=1; stream samples k=1..8 (k<<24) back-to-back.
  -> 4 windows, oldest first: {0,0,1,2,3}, {1,2,3,4,5}, {3,4,5,6,7}, {5,6,7,8,0}; `win_idx` 0..3; `done` one cycle after window 3; `busy` low afterward.
- Same config, hold win_ready=0 for 5 cycles when window 1 appears.
  -> `all_a` and `win_idx`=1 stable, `in_ready`=0 throughout; identical sequence on release; `stall_cnt`=5 with CWB_STALL_CNT_EN.
- Config PAD=0, N_REG=5, STRIDE=2, FRAME_LEN=9.
  -> N_OUT=3 windows {1..5}, {3..7}, {5..9}; no TAIL shifts; `done` after third acceptance.
- Random in_valid gaps (≈50%) with default N_REG=31, PAD=15, FRAME_LEN=64, samples 0.01*k.
  -> 32 windows; window j slice i equals sample (2j-15+i), or 0 when out of range; matches model exactly.
- Assert rst_n=0 after 3 samples, release, pulse `start`, stream 1..8 (small config).
  -> outputs zero during reset; the full correct 4-window sequence follows, with no stale data.
- Pulse `start` while busy mid-frame.
  -> ignored: counters and window sequence unaffected, exactly one `done`.

Source files
------------

// File: rtl/conv_window_buffer.sv
// conv_window_buffer: sliding N_REG-deep sample window with head/tail zero padding,
// emitted at the conv stride over a valid/ready handshake.
// Optional macro CWB_STALL_CNT_EN adds a 32-bit saturating backpressure counter output stall_cnt.
module conv_window_buffer #(
    parameter int WIDTH     = 32,
    parameter int N_REG     = 31,
    parameter int STRIDE    = 2,
    parameter int PAD       = 15,
    parameter int FRAME_LEN = 16384,
    parameter int CNT_BITS  = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic [N_REG*WIDTH-1:0] all_a,
    output logic [CNT_BITS-1:0]    win_idx,
    output logic                   busy,
    output logic                   done
`ifdef CWB_STALL_CNT_EN
    ,
    output logic [31:0]            stall_cnt
`endif
);
    localparam int N_OUT = (FRAME_LEN + 2 * PAD - N_REG) / STRIDE + 1;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] TAIL   = 2'd2;
    localparam logic [1:0] DRAIN  = 2'd3;
    localparam logic [CNT_BITS-1:0] ONE     = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] NREG_C  = CNT_BITS'(N_REG);
    localparam logic [CNT_BITS-1:0] NOUT_C  = CNT_BITS'(N_OUT);
    localparam logic [CNT_BITS-1:0] FLEN_C  = CNT_BITS'(FRAME_LEN);
    localparam logic [CNT_BITS-1:0] PAD_C   = CNT_BITS'(PAD);
    localparam logic [CNT_BITS-1:0] PH_LAST = CNT_BITS'(STRIDE - 1);
    logic [1:0]             state;
    logic [N_REG*WIDTH-1:0] sreg;
    logic [CNT_BITS-1:0]    vcnt;
    logic [CNT_BITS-1:0]    rcnt;
    logic [CNT_BITS-1:0]    fcnt;
    logic [CNT_BITS-1:0]    pcnt;
    logic [CNT_BITS-1:0]    vnext;
    logic [WIDTH-1:0]       nval;
    logic                   adv;
    logic                   acc;
    logic                   shift_in;
    logic                   shift;
    logic                   form;
    assign all_a = sreg;
    // Handshake and shift decisions; pcnt tracks the stride phase once the window is full.
    always_comb begin
        adv      = !win_valid || win_ready;
        acc      = win_valid && win_ready;
        in_ready = (state == STREAM) && adv && (rcnt < FLEN_C) && (fcnt < NOUT_C);
        shift_in = in_valid && in_ready;
        shift    = shift_in || ((state == TAIL) && adv && (fcnt < NOUT_C));
        nval     = shift_in ? in_data : '0;
        vnext    = vcnt + ONE;
        form     = shift && (vnext >= NREG_C) && (pcnt == '0);
    end
    // Shift register, window presentation and frame sequencing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sreg      <= '0;
            vcnt      <= '0;
            rcnt      <= '0;
            fcnt      <= '0;
            pcnt      <= '0;
            win_valid <= 1'b0;
            win_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (shift) begin
                sreg <= {nval, sreg[N_REG*WIDTH-1:WIDTH]};
                vcnt <= vnext;
                if (vnext >= NREG_C)
                    pcnt <= (pcnt == PH_LAST) ? '0 : pcnt + ONE;
            end
            if (form) begin
                win_valid <= 1'b1;
                win_idx   <= fcnt;
                fcnt      <= fcnt + ONE;
            end else if (acc) begin
                win_valid <= 1'b0;
            end
            if (shift_in)
                rcnt <= rcnt + ONE;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= STREAM;
                        sreg  <= '0;
                        vcnt  <= PAD_C;
                        rcnt  <= '0;
                        fcnt  <= '0;
                        pcnt  <= '0;
                        busy  <= 1'b1;
                    end
                end
                STREAM: begin
                    if ((shift_in && rcnt == FLEN_C - ONE) || fcnt == NOUT_C)
                        state <= TAIL;
                end
                default: begin
                    if (fcnt == NOUT_C) begin
                        state <= adv ? IDLE : DRAIN;
                        busy  <= !adv;
                        done  <= adv;
                    end
                end
            endcase
        end
    end
`ifdef CWB_STALL_CNT_EN
    // Cycles a presented window waits on the consumer during a frame, saturating.
    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (state == IDLE && start)
            stall_cnt <= '0;
        else if (busy && win_valid && !win_ready && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_conv_window_buffer.sv
// tb_conv_window_buffer: three configurations of conv_window_buffer checked against a window model.
module tb_conv_window_buffer;
    logic         clk;
    logic         rst_n;
    logic [2:0]   start;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         win_ready;
    logic [2:0]   in_ready;
    logic [2:0]   win_valid;
    logic [2:0]   busy;
    logic [2:0]   done;
    logic [159:0] a0;
    logic [159:0] a1;
    logic [991:0] a2;
    logic [14:0]  idx0;
    logic [14:0]  idx1;
    logic [14:0]  idx2;
`ifdef CWB_STALL_CNT_EN
    logic [31:0]  st0;
    logic [31:0]  st1;
    logic [31:0]  st2;
`endif
    logic [31:0]  smp [64];
    int n_assert = 0;
    int n_fail = 0;

    conv_window_buffer #(.N_REG(5), .PAD(2), .FRAME_LEN(8)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[0]), .win_valid(win_valid[0]), .win_ready(win_ready), .all_a(a0),
        .win_idx(idx0), .busy(busy[0]), .done(done[0])
`ifdef CWB_STALL_CNT_EN
        , .stall_cnt(st0)
`endif
    );
    conv_window_buffer #(.N_REG(5), .PAD(0), .FRAME_LEN(9)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[1]), .win_valid(win_valid[1]), .win_ready(win_ready), .all_a(a1),
        .win_idx(idx1), .busy(busy[1]), .done(done[1])
`ifdef CWB_STALL_CNT_EN
        , .stall_cnt(st1)
`endif
    );
    conv_window_buffer #(.N_REG(31), .PAD(15), .FRAME_LEN(64)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[2]), .win_valid(win_valid[2]), .win_ready(win_ready), .all_a(a2),
        .win_idx(idx2), .busy(busy[2]), .done(done[2])
`ifdef CWB_STALL_CNT_EN
        , .stall_cnt(st2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nreg(int k);
        return (k == 2) ? 31 : 5;
    endfunction
    function automatic int pad(int k);
        return (k == 0) ? 2 : (k == 1) ? 0 : 15;
    endfunction
    function automatic int flen(int k);
        return (k == 0) ? 8 : (k == 1) ? 9 : 64;
    endfunction
    function automatic int nout(int k);
        return (flen(k) + 2 * pad(k) - nreg(k)) / 2 + 1;
    endfunction
    function automatic logic [991:0] get_a(int k);
        return (k == 0) ? {832'b0, a0} : (k == 1) ? {832'b0, a1} : a2;
    endfunction
    function automatic logic [14:0] get_idx(int k);
        return (k == 0) ? idx0 : (k == 1) ? idx1 : idx2;
    endfunction
`ifdef CWB_STALL_CNT_EN
    function automatic logic [31:0] get_stall(int k);
        return (k == 0) ? st0 : (k == 1) ? st1 : st2;
    endfunction
`endif
    // window j, slice i holds input sample j*STRIDE-PAD+i, zero outside the frame
    function automatic logic [991:0] exp_win(int k, int j);
        logic [991:0] w;
        w = '0;
        for (int i = 0; i < nreg(k); i++) begin
            int s;
            s = j * 2 - pad(k) + i;
            if (s >= 0 && s < flen(k)) w[i*32 +: 32] = smp[s];
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_win(input string tag, input logic [991:0] got, input logic [991:0] exp);
        int s;
        s = 0;
        for (int i = 30; i >= 0; i--) if (got[i*32 +: 32] !== exp[i*32 +: 32]) s = i;
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: slice %0d observed %h expected %h", tag, s, got[s*32 +: 32], exp[s*32 +: 32]);
        end
    endtask

    task automatic chk_reset_state(input int k);
        chk("rst_in_ready", in_ready[k], 0);
        chk("rst_win_valid", win_valid[k], 0);
        chk("rst_busy", busy[k], 0);
        chk("rst_done", done[k], 0);
        chk("rst_win_idx", get_idx(k), 0);
        chk_win("rst_all_a", get_a(k), '0);
    endtask

    // Runs one frame on instance k starting at a negedge; ends at a negedge.
    task automatic run_frame(input int k, input int gap, input int stall_win, input int stall_len,
                             input int mid_start, input int rst_after);
        int sc, wc, dc, post, left, exp_stall;
        bit stl;
        sc = 0; wc = 0; dc = 0; post = 0; left = stall_len; exp_stall = 0;
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        for (int cyc = 0; cyc < 3000 && post < 3; cyc++) begin
            in_valid = (sc < flen(k)) && ($urandom_range(99) >= gap);
            in_data = (sc < flen(k)) ? smp[sc] : $urandom;
            stl = win_valid[k] && (get_idx(k) == 15'(stall_win)) && left > 0;
            win_ready = !stl;
            start[k] = (cyc == mid_start);
            #1;
            if (done[k]) begin
                dc++;
                chk("done_after_last", wc, nout(k));
            end
            chk("busy", busy[k], dc == 0);
            if (win_valid[k]) begin
                chk_win("window", get_a(k), exp_win(k, wc));
                chk("win_idx", get_idx(k), wc);
                if (stl) begin
                    chk("stall_in_ready", in_ready[k], 0);
                    left--;
                    exp_stall++;
                end
                if (win_ready) wc++;
            end
            if (in_valid && in_ready[k]) sc++;
            if (dc > 0) post++;
            if (rst_after >= 0 && sc == rst_after) break;
            @(negedge clk);
        end
        start[k] = 1'b0;
        in_valid = 1'b0;
        win_ready = 1'b1;
        if (rst_after >= 0) begin
            rst_n = 1'b0;
            @(negedge clk);
            chk_reset_state(k);
            @(negedge clk);
            chk_reset_state(k);
            rst_n = 1'b1;
        end else begin
            chk("done_count", dc, 1);
            chk("samples_taken", sc, flen(k));
            chk("windows_taken", wc, nout(k));
            chk("idle_in_ready", in_ready[k], 0);
            chk("idle_busy", busy[k], 0);
`ifdef CWB_STALL_CNT_EN
            chk("stall_cnt", get_stall(k), exp_stall);
`endif
        end
    endtask

    task automatic fill_ramp();
        for (int s = 0; s < 64; s++) smp[s] = 32'(s + 1) << 24;
    endtask

    initial begin
        rst_n = 1'b0;
        start = '0;
        in_valid = 1'b0;
        in_data = '0;
        win_ready = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) chk_reset_state(k);
        rst_n = 1'b1;
        @(negedge clk);
        fill_ramp();
        run_frame(0, 0, -1, 0, -1, -1);
        run_frame(0, 0, 1, 5, -1, -1);
        run_frame(1, 0, -1, 0, -1, -1);
        for (int s = 0; s < 64; s++) smp[s] = 32'($rtoi(0.01 * (s + 1) * 16777216.0 + 0.5));
        run_frame(2, 50, -1, 0, -1, -1);
        fill_ramp();
        run_frame(0, 0, -1, 0, -1, 3);
        run_frame(0, 0, -1, 0, -1, -1);
        run_frame(0, 30, -1, 0, 6, -1);
        for (int s = 0; s < 64; s++) smp[s] = $urandom;
        run_frame(1, 40, 2, 3, 4, -1);
        run_frame(2, 40, 3, 4, 10, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
